// File: rtl/sum_display_if.sv
// Signal bundle between the nibble adder stage and the two-digit display driver.
// The adder side drives the active-low sum; the display side returns segments, enables and err.
interface sum_display_if;
    logic [7:0] sum_n;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic       err;

    modport master (
        output sum_n,
        input  seg_n,
        input  an_n,
        input  err
    );

    modport slave (
        input  sum_n,
        output seg_n,
        output an_n,
        output err
    );
endinterface

// File: rtl/sum_display.sv
// Debounces an active-low sum bus and scans its value onto two multiplexed
// seven-segment digits, showing dashes when the value does not fit in 0..31.
module sum_display #(
    parameter int REFRESH_DIV   = 50000,
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    sum_display_if.slave  bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    logic [7:0]    s_reg;
    logic [CW-1:0] cnt_reg;
    logic [7:0]    disp_val_reg;
    logic [RW-1:0] ref_cnt_reg;
    logic          digit_sel_reg;
    logic [6:0]    seg_reg;
    logic [1:0]    an_reg;

    logic [7:0]    true_val;
    logic          same_val;
    logic          out_of_range;
    logic [4:0]    low_val;
    logic [4:0]    tens_val;
    logic [4:0]    ones_val;
    logic [6:0]    seg_next;
    logic [1:0]    an_next;

    function automatic logic [6:0] seg_code(input logic [4:0] digit);
        logic [6:0] code;
        case (digit)
            5'd0:    code = 7'h40;
            5'd1:    code = 7'h79;
            5'd2:    code = 7'h24;
            5'd3:    code = 7'h30;
            5'd4:    code = 7'h19;
            5'd5:    code = 7'h12;
            5'd6:    code = 7'h02;
            5'd7:    code = 7'h78;
            5'd8:    code = 7'h00;
            5'd9:    code = 7'h10;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    assign true_val     = ~bus.sum_n;
    assign same_val     = (true_val == s_reg);
    assign out_of_range = |disp_val_reg[7:5];
    assign low_val      = disp_val_reg[4:0];

    // Output decode works from the registered display value only, so sum_n never reaches an output combinationally.
    always_comb begin
        tens_val = low_val / 5'd10;
        ones_val = low_val % 5'd10;
        seg_next = 7'h7F;
        an_next  = digit_sel_reg ? 2'b01 : 2'b10;
        if (out_of_range) begin
            seg_next = 7'h3F;
        end else if (!digit_sel_reg) begin
            seg_next = seg_code(ones_val);
        end else if (tens_val != 5'd0) begin
            seg_next = seg_code(tens_val);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg         <= 8'd0;
            cnt_reg       <= '0;
            disp_val_reg  <= 8'd0;
            ref_cnt_reg   <= '0;
            digit_sel_reg <= 1'b0;
            seg_reg       <= 7'h7F;
            an_reg        <= 2'b11;
        end else begin
            s_reg <= true_val;

            // A change on the load edge wins: the count restarts and the display keeps its value.
            if (!same_val) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (same_val && (cnt_reg == CNT_LOAD)) begin
                disp_val_reg <= s_reg;
            end

            if (ref_cnt_reg == REF_LAST) begin
                ref_cnt_reg   <= '0;
                digit_sel_reg <= ~digit_sel_reg;
            end else begin
                ref_cnt_reg <= ref_cnt_reg + 1'b1;
            end

            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign bus.seg_n = seg_reg;
    assign bus.an_n  = an_reg;
    assign bus.err   = out_of_range;

endmodule

// File: doc/sum_display.md
SUM_DISPLAY -- requirements
Module: sum_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each digit is held active during scanning (minimum 2).
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive unchanged cycles required before a new sum is displayed (minimum 1).
REQ-003 Port clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port sum_n  input  8  active-low sum bus from the nibble adder stage; true value = ~sum_n.
REQ-006 Port seg_n  output  7  active-low segments; bit0=a through bit6=g.
REQ-007 Port an_n  output  2  active-low digit enables; bit0=ones digit, bit1=tens digit.
REQ-008 Port err  output  1  high while the displayed value is out of range.

Function
REQ-009 Sample register s SHALL load ~sum_n on every rising edge.
REQ-010 Stability counter cnt SHALL clear to 0 when ~sum_n != s, else increment, saturating at STABLE_CYCLES.
REQ-011 disp_val SHALL load s on an edge where cnt == STABLE_CYCLES-1 and ~sum_n == s; otherwise disp_val holds.
REQ-012 A constant input change first sampled at edge 0 SHALL appear in disp_val after edge STABLE_CYCLES; earlier changes restart the count.
REQ-013 If an input change and a pending load fall on the same edge, the change SHALL win: cnt clears and disp_val does not load.
REQ-014 err SHALL be high when disp_val[7:5] != 0 (bus nonzero in the upper 3 bits of the true value), else low.
REQ-015 When err is low, tens = disp_val[4:0] / 10 (0..3) and ones = disp_val[4:0] mod 10; both use integer division.
REQ-016 Ones digit SHALL always display; tens digit SHALL be blanked (seg_n = 7F hex) when tens == 0.
REQ-017 When err is high, both digits SHALL show a dash (seg_n = 3F hex).
REQ-018 Segment codes (seg_n, hex) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-019 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; digit_sel toggles on the wrap edge.
REQ-020 digit_sel=0 selects ones (an_n = 2'b10); digit_sel=1 selects tens (an_n = 2'b01); both enables are never low together.
REQ-021 seg_n and an_n SHALL be registered each edge from the pre-edge digit_sel and disp_val.
REQ-022 seg_n and an_n SHALL change on the same edge, giving one cycle of lag and no mismatched segment/enable pair.
REQ-023 No combinational path SHALL exist from sum_n to any output.

Reset
REQ-024 On a rising edge with rst high, the following SHALL reset: s=0, cnt=0, disp_val=0, refresh counter=0, digit_sel=0, seg_n=7F, an_n=2'b11, err=0.
REQ-025 Reset asserted mid-scan or mid-stability-count SHALL abort the operation at that edge; no pending load completes.
REQ-026 On the first edge after rst falls, an_n SHALL be 2'b10 and seg_n SHALL be 40 (shows 0).

Verification
REQ-027 Reset, then sum_n=FF (value 0), STABLE_CYCLES=4, REFRESH_DIV=4 -> ones shows 40, tens blank 7F; an_n alternates 10/01 every 4 cycles; err=0.
REQ-028 sum_n=E2 (value 29) held -> disp_val=29 after edge 4; ones=10 (9), tens=24 (2).
REQ-029 sum_n toggles between E2 and F0 every 2 cycles for 20 cycles -> disp_val stays at its prior value throughout; it loads only after the bus is held 4+ cycles.
REQ-030 sum_n=DF (value 32) held -> err=1 and both digits 3F; then sum_n=E1 (value 30) held -> err=0, tens=30 (3), ones=40 (0).
REQ-031 rst pulsed for 1 cycle mid-count and mid-scan -> next edge outputs 7F/11; after release, outputs follow REQ-026; disp_val=0 until re-stabilised.
REQ-032 Change to sum_n on the exact edge where the load is pending -> no load; disp_val keeps its old value and cnt=0.
